lv_owt_req_sched: RTL

LV_OWT_REQ_SCHED -- requirements
Module: lv_owt_req_sched

---
 rtl/lv_owt_req_sched_pkg.sv | 22 ++
 rtl/lv_owt_req_sched_if.sv | 23 ++
 rtl/lv_owt_poll_tmr.sv | 29 ++
 rtl/lv_owt_req_sched.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lv_owt_req_sched_pkg.sv
// Shared types for the OWT request scheduler: FSM states, frame sources, op codes.
package lv_owt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_SPI  = 2'd0,
    SRC_WDG  = 2'd1,
    SRC_POLL = 2'd2
  } src_e;

  localparam logic RD_OP = 1'b1;
  localparam logic WR_OP = 1'b0;

  localparam logic [6:0] ADC_ADDR_DEF = 7'h7F;

endpackage

// File: rtl/lv_owt_req_sched_if.sv
// Frame request/response bus between the scheduler (master) and the OWT TX controller (slave).
interface lv_owt_req_sched_if #(
  parameter int REG_AW = 7,
  parameter int REG_DW = 8
) ();
  logic              o_owt_wr_req;
  logic              o_owt_rd_req;
  logic [REG_AW-1:0] o_owt_addr;
  logic [REG_DW-1:0] o_owt_data;
  logic              i_owt_ack;
  logic              i_owt_err;
  logic [REG_DW-1:0] i_owt_rdata;

  modport master (
    output o_owt_wr_req, o_owt_rd_req, o_owt_addr, o_owt_data,
    input  i_owt_ack, i_owt_err, i_owt_rdata
  );

  modport slave (
    input  o_owt_wr_req, o_owt_rd_req, o_owt_addr, o_owt_data,
    output i_owt_ack, i_owt_err, i_owt_rdata
  );
endinterface

// File: rtl/lv_owt_poll_tmr.sv
// Free-running status-poll timer; raises a single pending flag per period, no queueing.
module lv_owt_poll_tmr #(
  parameter int PERIOD = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_pend
);
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [TW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == TW'(PERIOD - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      cnt    <= '0;
      o_pend <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + TW'(1);
      // a wrap landing on a grant re-arms: the new period has already elapsed
      if (wrap)       o_pend <= 1'b1;
      else if (i_clr) o_pend <= 1'b0;
    end
  end
endmodule

// File: rtl/lv_owt_req_sched.sv
// Arbitrates SPI / watchdog ADC / status-poll reads onto the OWT frame bus.
// Optional retry path: define LV_OWT_REQ_RETRY_EN.
module lv_owt_req_sched
  import lv_owt_pkg::*;
#(
  parameter int                REG_AW          = 7,
  parameter int                REG_DW          = 8,
  parameter logic [REG_AW-1:0] ADC_ADDR        = REG_AW'(ADC_ADDR_DEF),
  parameter logic [REG_AW-1:0] POLL_ADDR       = REG_AW'(7'h10),
  parameter int                POLL_PERIOD_CYC = 1000,
  parameter int                GAP_CYC         = 16,
  parameter int                RETRY_MAX       = 2,
  parameter int                STARVE_MAX      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_spi_wr_req,
  input  logic              i_spi_rd_req,
  input  logic [REG_AW-1:0] i_spi_addr,
  input  logic [REG_DW-1:0] i_spi_data,
  output logic              o_spi_ack,
  output logic              o_spi_err,
  output logic [REG_DW-1:0] o_spi_rdata,
  input  logic              i_wdg_req,
  output logic              o_wdg_ack,
  output logic [REG_DW-1:0] o_wdg_rdata,
  input  logic              i_poll_en,
  output logic              o_poll_vld,
  output logic [REG_DW-1:0] o_poll_data,
  output logic              o_busy,
  lv_owt_req_sched_if.master owt
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int RW = $clog2(RETRY_MAX + 1);

  state_e            state, state_nxt;
  src_e              lat_src;
  logic              lat_rd;
  logic [REG_AW-1:0] lat_addr;
  logic [REG_DW-1:0] lat_data;
  logic [SW-1:0]     starve_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              poll_pend;

  logic spi_req, wdg_force, arb, any_req, gnt_spi, gnt_wdg, gnt_poll;
  logic owt_done, retry_go, retry_pend, complete, gap_last;

  assign arb       = (state == ST_IDLE);
  assign spi_req   = i_spi_wr_req | i_spi_rd_req;
  assign wdg_force = i_wdg_req && (starve_cnt == SW'(STARVE_MAX));
  assign any_req   = spi_req | i_wdg_req | poll_pend;
  assign gnt_spi   = arb && spi_req && !wdg_force;
  assign gnt_wdg   = arb && i_wdg_req && (wdg_force || !spi_req);
  assign gnt_poll  = arb && poll_pend && !spi_req && !i_wdg_req;

  assign owt_done  = (state == ST_WAIT) && owt.i_owt_ack;
  assign complete  = owt_done && !retry_go;

  // The IDLE arbitration cycle is the last quiet cycle of a normal gap, so
  // GAP itself is one cycle shorter unless a retry jumps straight to ISSUE.
  assign gap_last  = (gap_cnt == (retry_pend ? GW'(GAP_CYC - 1) : GW'(GAP_CYC - 2)));

  lv_owt_poll_tmr #(.PERIOD(POLL_PERIOD_CYC)) u_poll_tmr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_poll_en),
    .i_clr  (gnt_poll),
    .o_pend (poll_pend)
  );

`ifdef LV_OWT_REQ_RETRY_EN
  logic [RW-1:0] retry_cnt;

  assign retry_go = owt_done && owt.i_owt_err && (retry_cnt < RW'(RETRY_MAX));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
    end else begin
      if (retry_go) begin
        retry_cnt  <= retry_cnt + RW'(1);
        retry_pend <= 1'b1;
      end else if (complete) begin
        retry_cnt  <= '0;
      end
      if (state == ST_GAP && gap_last) retry_pend <= 1'b0;
    end
  end
`else
  assign retry_go   = 1'b0;
  assign retry_pend = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (owt.i_owt_ack) state_nxt = ST_GAP;
      ST_GAP:   if (gap_last) state_nxt = retry_pend ? ST_ISSUE : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    owt.o_owt_wr_req = 1'b0;
    owt.o_owt_rd_req = 1'b0;
    if (state == ST_ISSUE || state == ST_WAIT) begin
      owt.o_owt_wr_req = (lat_rd == WR_OP);
      owt.o_owt_rd_req = (lat_rd == RD_OP);
    end
    owt.o_owt_addr = lat_addr;
    owt.o_owt_data = lat_data;
    o_busy         = (state != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lat_src     <= SRC_SPI;
      lat_rd      <= WR_OP;
      lat_addr    <= '0;
      lat_data    <= '0;
      starve_cnt  <= '0;
      gap_cnt     <= '0;
      o_spi_ack   <= 1'b0;
      o_spi_err   <= 1'b0;
      o_spi_rdata <= '0;
      o_wdg_ack   <= 1'b0;
      o_wdg_rdata <= '0;
      o_poll_vld  <= 1'b0;
      o_poll_data <= '0;
    end else begin
      if (gnt_spi) begin
        lat_src  <= SRC_SPI;
        lat_rd   <= i_spi_rd_req ? RD_OP : WR_OP;
        lat_addr <= i_spi_addr;
        lat_data <= i_spi_rd_req ? '0 : i_spi_data;
      end else if (gnt_wdg) begin
        lat_src  <= SRC_WDG;
        lat_rd   <= RD_OP;
        lat_addr <= ADC_ADDR;
        lat_data <= '0;
      end else if (gnt_poll) begin
        lat_src  <= SRC_POLL;
        lat_rd   <= RD_OP;
        lat_addr <= POLL_ADDR;
        lat_data <= '0;
      end

      if (gnt_wdg)
        starve_cnt <= '0;
      else if (gnt_spi && i_wdg_req && starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);

      gap_cnt <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;

      o_spi_ack  <= complete && lat_src == SRC_SPI;
      o_spi_err  <= complete && lat_src == SRC_SPI && owt.i_owt_err;
      o_wdg_ack  <= complete && lat_src == SRC_WDG;
      o_poll_vld <= complete && lat_src == SRC_POLL;
      if (complete && lat_src == SRC_SPI)
        o_spi_rdata <= (lat_rd == RD_OP && !owt.i_owt_err) ? owt.i_owt_rdata : '0;
      if (complete && lat_src == SRC_WDG)
        o_wdg_rdata <= owt.i_owt_err ? '0 : owt.i_owt_rdata;
      if (complete && lat_src == SRC_POLL)
        o_poll_data <= owt.i_owt_err ? '0 : owt.i_owt_rdata;
    end
  end
endmodule
